// File: rtl/gbuff_stream_reader_if.sv
// gbuff_stream_reader_if
//   Bundles the burst-request, buffer-read and output-stream signals of
//   gbuff_stream_reader.
//   slave  : reader-side view (used by gbuff_stream_reader)
//   master : requester / buffer / sink view (used by the surrounding logic)
//   Signals: start, base_addr, length, busy, done           burst control
//            buf_ram_en, buf_index, buf_data                global buffer read port
//            out_valid, out_ready, out_data, out_last       output stream
//            stride                                         only with GBUFF_RD_STRIDE_EN
interface gbuff_stream_reader_if #(
    parameter int unsigned ADDR_BITS = 12,
    parameter int unsigned DATA_BITS = 32
);
    logic                 start;
    logic [ADDR_BITS-1:0] base_addr;
    logic [ADDR_BITS:0]   length;
`ifdef GBUFF_RD_STRIDE_EN
    logic [ADDR_BITS-1:0] stride;
`endif
    logic                 busy;
    logic                 done;
    logic                 buf_ram_en;
    logic [ADDR_BITS-1:0] buf_index;
    logic [DATA_BITS-1:0] buf_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_BITS-1:0] out_data;
    logic                 out_last;

    modport slave (
`ifdef GBUFF_RD_STRIDE_EN
        input  stride,
`endif
        input  start, base_addr, length, buf_data, out_ready,
        output busy, done, buf_ram_en, buf_index, out_valid, out_data, out_last
    );

    modport master (
`ifdef GBUFF_RD_STRIDE_EN
        output stride,
`endif
        output start, base_addr, length, buf_data, out_ready,
        input  busy, done, buf_ram_en, buf_index, out_valid, out_data, out_last
    );
endinterface

// File: rtl/gbuff_stream_reader.sv
// gbuff_stream_reader
//   Burst reader for the on-chip global buffer. Given a base index and a word
//   count it walks the buffer (combinational read) and streams the words out
//   on a valid/ready interface with a last flag.
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    gbuff_stream_reader_if.slave (burst control, buffer read port,
//            output stream)
//   Configuration macro: GBUFF_RD_STRIDE_EN adds a per-burst stride latched
//   with base_addr; without it the read pointer advances by 1.
module gbuff_stream_reader #(
    parameter int unsigned ADDR_BITS = 12,
    parameter int unsigned DATA_BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gbuff_stream_reader_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [ADDR_BITS:0] REM_ONE = {{ADDR_BITS{1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] rd_ptr_q;
    logic [ADDR_BITS:0]   remaining_q;
    logic [DATA_BITS-1:0] out_data_q;
    logic                 out_valid_q;
    logic                 out_last_q;
    logic                 done_q;
    logic [ADDR_BITS-1:0] step;

    logic accept;
    logic empty_req;
    logic fetch;
    logic drain_hs;

`ifdef GBUFF_RD_STRIDE_EN
    logic [ADDR_BITS-1:0] stride_q;
    assign step = stride_q;
`else
    assign step = {{(ADDR_BITS-1){1'b0}}, 1'b1};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        empty_req = 1'b0;
        fetch     = 1'b0;
        drain_hs  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.length != '0) begin
                        accept  = 1'b1;
                        state_d = RUN;
                    end else begin
                        empty_req = 1'b1;
                    end
                end
            end
            RUN: begin
                fetch = (!out_valid_q || bus.out_ready) && (remaining_q != '0);
                if (fetch && remaining_q == REM_ONE) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid_q && bus.out_ready) begin
                    drain_hs = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef GBUFF_RD_STRIDE_EN
            stride_q    <= '0;
`endif
        end else begin
            done_q <= empty_req || drain_hs;
            if (accept) begin
                rd_ptr_q    <= bus.base_addr;
                remaining_q <= bus.length;
`ifdef GBUFF_RD_STRIDE_EN
                stride_q    <= bus.stride;
`endif
            end
            if (fetch) begin
                out_data_q  <= bus.buf_data;
                out_valid_q <= 1'b1;
                out_last_q  <= (remaining_q == REM_ONE);
                remaining_q <= remaining_q - REM_ONE;
                // The pointer is not advanced past the final word so that
                // buf_index keeps showing the last index read once RUN ends.
                if (remaining_q != REM_ONE) begin
                    rd_ptr_q <= rd_ptr_q + step;
                end
            end
            if (drain_hs) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.buf_ram_en = (state_q == RUN);
    assign bus.buf_index  = rd_ptr_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_last   = out_last_q;

endmodule

// File: tb/tb_gbuff_stream_reader.sv
`timescale 1ns/1ps
module tb_gbuff_stream_reader;
    localparam int unsigned AB    = 12;
    localparam int unsigned DB    = 32;
    localparam int unsigned DEPTH = 1 << AB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gbuff_stream_reader_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

    gbuff_stream_reader #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Buffer model: combinational read, zero when disabled.
    logic [DB-1:0] mem [DEPTH];
    assign bus.buf_data = bus.buf_ram_en ? mem[bus.buf_index] : '0;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [DB:0] sb_q [$];          // {last, data}

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard pops on handshakes plus per-cycle rules.
    logic        prev_stall = 1'b0;
    logic [DB:0] prev_beat  = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy_and_done", bus.busy & bus.done, 1'b0);
            if (bus.out_last) check("last_without_valid", bus.out_valid, 1'b1);
            if (prev_stall) begin
                check("stall_valid_held", bus.out_valid, 1'b1);
                check("stall_beat_held", {bus.out_last, bus.out_data}, prev_beat);
            end
            if (bus.out_valid && bus.out_ready) begin
                check("beat_expected", sb_q.size() > 0, 1'b1);
                if (sb_q.size() > 0) check("beat", {bus.out_last, bus.out_data}, sb_q.pop_front());
            end
            prev_stall = bus.out_valid & ~bus.out_ready;
            prev_beat  = {bus.out_last, bus.out_data};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_busy"},   bus.busy, 1'b0);
        check({tag, "_done"},   bus.done, 1'b0);
        check({tag, "_ram_en"}, bus.buf_ram_en, 1'b0);
        check({tag, "_index"},  bus.buf_index, '0);
        check({tag, "_valid"},  bus.out_valid, 1'b0);
        check({tag, "_data"},   bus.out_data, '0);
        check({tag, "_last"},   bus.out_last, 1'b0);
    endtask

    task automatic drive_req(input logic [AB-1:0] base, input logic [AB:0] len, input logic [AB-1:0] strd);
        bus.base_addr = base;
        bus.length    = len;
`ifdef GBUFF_RD_STRIDE_EN
        bus.stride    = strd;
`endif
        bus.start     = 1'b1;
        @(posedge clk); #1;
        // Scramble request inputs: they must have been latched at acceptance.
        bus.start     = 1'b0;
        bus.base_addr = AB'($urandom);
        bus.length    = (AB+1)'($urandom);
`ifdef GBUFF_RD_STRIDE_EN
        bus.stride    = AB'($urandom);
`endif
    endtask

    task automatic push_exp(input logic [AB-1:0] base, input logic [AB:0] len, input logic [AB-1:0] strd);
        logic [AB-1:0] a;
        a = base;
        for (int unsigned k = 0; k < len; k++) begin
            sb_q.push_back({(k == len - 1), mem[a]});
            a = a + strd;
        end
    endtask

    // mode 0: ready held 1; 1: ready pattern 1,0,0,1; 2: random ready.
    // Latencies count cycles after the acceptance cycle (0 = the cycle after).
    task automatic run(input logic [AB-1:0] base, input logic [AB:0] len, input logic [AB-1:0] strd,
                       input int unsigned mode, input bit glitch, input int unsigned budget,
                       output int unsigned lat_done, output int unsigned lat_valid);
        int unsigned n;
        push_exp(base, len, strd);
        drive_req(base, len, strd);
        n = 0;
        lat_valid = 32'hFFFF_FFFF;
        while (!bus.done && n < budget) begin
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (n % 4 == 0) || (n % 4 == 3);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            if (glitch) bus.start = (n == 1);
            if (bus.out_valid && lat_valid == 32'hFFFF_FFFF) lat_valid = n;
            @(posedge clk); #1;
            n++;
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        lat_done = n;
        check("done_within_budget", n < budget, 1'b1);
        check("sb_drained", sb_q.size(), 0);
    endtask

    task automatic check_done_pulse();
        @(posedge clk); #1;
        check("done_is_pulse", bus.done, 1'b0);
    endtask

    initial begin
        int unsigned ld, lv;
        logic [AB-1:0] rb;
        logic [AB:0]   rl;

        for (int unsigned i = 0; i < DEPTH; i++) mem[i] = $urandom;
        for (int unsigned k = 0; k < 4; k++) mem[16 + k] = 32'hA0 + k;

        bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.out_ready = 1'b1;
`ifdef GBUFF_RD_STRIDE_EN
        bus.stride = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic burst, ready held: first valid at T+2, done at T+6.
        run(12'h010, 13'd4, 12'd1, 0, 1'b0, 200, ld, lv);
        check("t1_first_valid_lat", lv, 1);
        check("t1_done_lat", ld, 5);
        check_done_pulse();

        // Same burst under backpressure.
        run(12'h010, 13'd4, 12'd1, 1, 1'b0, 200, ld, lv);
        check("t2_first_valid_lat", lv, 1);
        check_done_pulse();

        // Wrap at the top of the buffer; index holds the last read afterwards.
        run(12'hFFE, 13'd3, 12'd1, 0, 1'b0, 200, ld, lv);
        check("t3_done_lat", ld, 4);
        check("t3_index_hold", bus.buf_index, 12'h000);
        check("t3_ram_en_off", bus.buf_ram_en, 1'b0);
        check_done_pulse();

        // Empty burst.
        run(12'h123, 13'd0, 12'd1, 0, 1'b0, 20, ld, lv);
        check("t4_done_lat", ld, 0);
        check("t4_valid", bus.out_valid, 1'b0);
        check("t4_busy", bus.busy, 1'b0);
        check("t4_ram_en", bus.buf_ram_en, 1'b0);
        check_done_pulse();

        // Reset after two beats of an 8-word burst.
        push_exp(12'h200, 13'd8, 12'd1);
        bus.out_ready = 1'b1;
        drive_req(12'h200, 13'd8, 12'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_idle("t5_mid_rst");
        check("t5_beats_before_rst", sb_q.size(), 6);
        sb_q.delete();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int unsigned c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("t5_no_done", bus.done, 1'b0);
            check("t5_no_valid", bus.out_valid, 1'b0);
        end
        run(12'h300, 13'd5, 12'd1, 2, 1'b0, 200, ld, lv);
        check("t5_restart_first_valid", lv, 1);
        check_done_pulse();

        // Full-depth burst: every entry once.
        run(12'h005, 13'd4096, 12'd1, 0, 1'b0, 5000, ld, lv);
        check("full_done_lat", ld, 4097);
        check("full_index_hold", bus.buf_index, 12'h004);
        check_done_pulse();

        // Random bursts with random backpressure and mid-burst start glitches.
        for (int unsigned r = 0; r < 4; r++) begin
            rb = AB'($urandom);
            rl = (AB+1)'($urandom_range(1, 20));
            run(rb, rl, 12'd1, 2, 1'b1, 400, ld, lv);
            check_done_pulse();
        end

`ifdef GBUFF_RD_STRIDE_EN
        run(12'h100, 13'd3, 12'd4, 0, 1'b1, 200, ld, lv);
        check("s1_done_lat", ld, 4);
        check("s1_index_hold", bus.buf_index, 12'h108);
        check_done_pulse();
        run(12'h050, 13'd5, 12'd0, 1, 1'b0, 200, ld, lv);
        check("s2_index_hold", bus.buf_index, 12'h050);
        check_done_pulse();
        run(12'hFF0, 13'd6, 12'd7, 2, 1'b1, 200, ld, lv);
        check_done_pulse();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
